// File: rtl/doodle_physics.sv
// Per-frame motion integrator for the doodle sprite: gravity, platform bounce,
// floor clamp, horizontal wrap and camera scroll, advanced once per frame tick.
module doodle_physics #(
  parameter int SCREEN_WIDTH  = 640,
  parameter int EARTH         = 440,
  parameter int DOODLE_HEIGHT = 40,
  parameter int START_X       = 300,
  parameter int FLOOR_Y       = 410,
  parameter int JUMP_VELOCITY = 14,
  parameter int GRAVITY       = 1,
  parameter int MAX_FALL      = 15,
  parameter int SCROLL_LINE   = 160
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              calculation_time,
  input  logic signed [8:0] delta_x,
  input  logic [1:0]        game_state,
  input  logic              platform_hit,
  output logic [9:0]        doodle_x,
  output logic [9:0]        doodle_y,
  output logic signed [6:0] velocity_y,
  output logic [6:0]        scroll,
  output logic              landed
);

  localparam logic signed [11:0] SCREEN_W12 = 12'(SCREEN_WIDTH);
  localparam logic signed [11:0] FLOOR_12   = 12'(FLOOR_Y);
  localparam logic signed [11:0] SCROLL_12  = 12'(SCROLL_LINE);
  localparam logic [9:0]         RESET_X    = 10'(START_X);
  localparam logic [9:0]         RESET_Y    = 10'(EARTH - DOODLE_HEIGHT);
  localparam logic [9:0]         FLOOR_Y10  = 10'(FLOOR_Y);
  localparam logic [9:0]         SCROLL_Y10 = 10'(SCROLL_LINE);
  localparam logic signed [6:0]  LAUNCH_VY  = 7'(-JUMP_VELOCITY);
  localparam logic signed [7:0]  GRAVITY_8  = 8'(GRAVITY);
  localparam logic signed [7:0]  MAX_FALL_8 = 8'(MAX_FALL);
  localparam logic signed [6:0]  MAX_FALL_7 = 7'(MAX_FALL);

  logic [9:0]         x_reg, x_next;
  logic [9:0]         y_reg, y_next;
  logic signed [6:0]  vy_reg, vy_next;
  logic [6:0]         scroll_reg, scroll_next;
  logic               landed_reg, landed_next;

  logic signed [11:0] x_sum, x_wrap, y_c, scroll_diff;
  logic signed [7:0]  vy_grav;
  logic               bounce;

  always_comb begin
    x_sum       = $signed({2'b00, x_reg}) + $signed({{3{delta_x[8]}}, delta_x});
    x_wrap      = x_sum;
    if (x_sum < 12'sd0)
      x_wrap = x_sum + SCREEN_W12;
    else if (x_sum >= SCREEN_W12)
      x_wrap = x_sum - SCREEN_W12;

    y_c         = $signed({2'b00, y_reg}) + $signed({{5{vy_reg[6]}}, vy_reg});
    scroll_diff = SCROLL_12 - y_c;
    vy_grav     = $signed({vy_reg[6], vy_reg}) + GRAVITY_8;
    // Contact only counts on the way down; a hit while rising passes through.
    bounce      = !vy_reg[6] && platform_hit;

    x_next      = x_reg;
    y_next      = y_reg;
    vy_next     = vy_reg;
    scroll_next = scroll_reg;
    landed_next = landed_reg;

    case (game_state)
      2'd0: begin
        x_next      = RESET_X;
        y_next      = RESET_Y;
        vy_next     = LAUNCH_VY;
        scroll_next = 7'd0;
        landed_next = 1'b0;
      end
      2'd1: begin
        x_next = x_wrap[9:0];
        if (bounce) begin
          vy_next     = LAUNCH_VY;
          landed_next = 1'b1;
        end else begin
          vy_next     = (vy_grav > MAX_FALL_8) ? MAX_FALL_7 : vy_grav[6:0];
          landed_next = 1'b0;
        end
        scroll_next = 7'd0;
        y_next      = y_c[9:0];
        if (y_c < SCROLL_12) begin
          y_next      = SCROLL_Y10;
          scroll_next = scroll_diff[6:0];
        end else if (y_c > FLOOR_12) begin
          // The floor stops a fall but must not cancel a bounce taken on the same frame.
          y_next = FLOOR_Y10;
          if (!bounce)
            vy_next = 7'sd0;
        end
      end
      default: begin
        scroll_next = 7'd0;
        landed_next = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      x_reg      <= RESET_X;
      y_reg      <= RESET_Y;
      vy_reg     <= LAUNCH_VY;
      scroll_reg <= 7'd0;
      landed_reg <= 1'b0;
    end else if (calculation_time) begin
      x_reg      <= x_next;
      y_reg      <= y_next;
      vy_reg     <= vy_next;
      scroll_reg <= scroll_next;
      landed_reg <= landed_next;
    end
  end

  assign doodle_x   = x_reg;
  assign doodle_y   = y_reg;
  assign velocity_y = vy_reg;
  assign scroll     = scroll_reg;
  assign landed     = landed_reg;

  logic unused_bits;
  assign unused_bits = &{1'b0, x_wrap[11:10], y_c[11:10], scroll_diff[11:7], vy_grav[7]};

endmodule
